// File: rtl/arm_cpu.sv
// ============================================================================
// Module      : arm_cpu
// Description : Single-cycle ARM-subset processor. Supports AND/SUB/ADD/ORR/CMP
//               data processing, LDR/STR with immediate offset, and B. All
//               instructions are conditionally executed against an NZCV register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] read_data,
  output logic        mem_write,
  output logic [31:0] pc,
  output logic [31:0] write_data,
  output logic [31:0] alu_result
);

  localparam logic [3:0] c_CMD_AND = 4'b0000;
  localparam logic [3:0] c_CMD_SUB = 4'b0010;
  localparam logic [3:0] c_CMD_ADD = 4'b0100;
  localparam logic [3:0] c_CMD_CMP = 4'b1010;
  localparam logic [3:0] c_CMD_ORR = 4'b1100;
  localparam logic [3:0] c_PC_IDX  = 4'hF;

  // Architectural state
  logic [31:0] r_pc;
  logic [3:0]  r_flags;            // {N, Z, C, V}
  logic [31:0] r_rf [15];          // R0-R14; R15 is the pc

  // Instruction fields
  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic        w_imm_op;
  logic [3:0]  w_cmd;
  logic        w_s_bit;
  logic        w_up;
  logic [3:0]  w_rn;
  logic [3:0]  w_rd;
  logic [3:0]  w_rm;

  // Decode / control
  logic        w_is_dp;
  logic        w_is_mem;
  logic        w_is_br;
  logic        w_dp_valid;
  logic        w_cond_ok;
  logic        w_exec;
  logic        w_reg_we;
  logic        w_flag_we;
  logic        w_branch;

  // Datapath
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus8;
  logic [3:0]  w_ra2;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [4:0]  w_rot;
  logic [63:0] w_rot64;
  logic [31:0] w_op2;
  logic [31:0] w_src_b;
  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic        w_v_add;
  logic        w_v_sub;
  logic [31:0] w_alu;
  logic        w_alu_c;
  logic        w_alu_v;
  logic        w_arith;
  logic [31:0] w_br_off;
  logic [31:0] w_br_target;
  logic [31:0] w_result;

  assign w_cond   = instr[31:28];
  assign w_op     = instr[27:26];
  assign w_imm_op = instr[25];
  assign w_cmd    = instr[24:21];
  assign w_s_bit  = instr[20];
  assign w_up     = instr[23];
  assign w_rn     = instr[19:16];
  assign w_rd     = instr[15:12];
  assign w_rm     = instr[3:0];

  assign w_is_dp  = (w_op == 2'b00);
  assign w_is_mem = (w_op == 2'b01);
  assign w_is_br  = (w_op == 2'b10);

  // CMP without S has no defined meaning here and is treated as unsupported
  assign w_dp_valid = (w_cmd == c_CMD_AND) || (w_cmd == c_CMD_SUB) ||
                      (w_cmd == c_CMD_ADD) || (w_cmd == c_CMD_ORR) ||
                      ((w_cmd == c_CMD_CMP) && w_s_bit);

  // Condition-code evaluation against the current NZCV flags
  always_comb begin
    w_cond_ok = 1'b0;
    case (w_cond)
      4'h0: w_cond_ok = r_flags[2];
      4'h1: w_cond_ok = ~r_flags[2];
      4'h2: w_cond_ok = r_flags[1];
      4'h3: w_cond_ok = ~r_flags[1];
      4'h4: w_cond_ok = r_flags[3];
      4'h5: w_cond_ok = ~r_flags[3];
      4'h6: w_cond_ok = r_flags[0];
      4'h7: w_cond_ok = ~r_flags[0];
      4'h8: w_cond_ok = r_flags[1] & ~r_flags[2];
      4'h9: w_cond_ok = ~r_flags[1] | r_flags[2];
      4'hA: w_cond_ok = (r_flags[3] == r_flags[0]);
      4'hB: w_cond_ok = (r_flags[3] != r_flags[0]);
      4'hC: w_cond_ok = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'hD: w_cond_ok = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'hE: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  assign w_exec    = w_cond_ok;
  assign w_reg_we  = w_exec & ((w_is_dp & w_dp_valid & (w_cmd != c_CMD_CMP)) |
                               (w_is_mem & w_s_bit));
  assign w_flag_we = w_exec & w_is_dp & w_dp_valid & w_s_bit;
  assign mem_write = w_exec & w_is_mem & ~w_s_bit;
  assign w_branch  = w_exec & w_is_br;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_plus8 = r_pc + 32'd8;

  // Port 2 serves Rm for data processing and Rd (store data) otherwise
  assign w_ra2 = w_is_dp ? w_rm : w_rd;
  assign w_rd1 = (w_rn  == c_PC_IDX) ? w_pc_plus8 : r_rf[w_rn];
  assign w_rd2 = (w_ra2 == c_PC_IDX) ? w_pc_plus8 : r_rf[w_ra2];
  assign write_data = w_rd2;

  // Immediate operand: imm8 rotated right by twice the rotate field
  assign w_rot   = {instr[11:8], 1'b0};
  assign w_rot64 = {24'd0, instr[7:0], 24'd0, instr[7:0]} >> w_rot;
  assign w_op2   = w_imm_op ? w_rot64[31:0] : w_rd2;
  assign w_src_b = w_is_dp ? w_op2 : {20'd0, instr[11:0]};

  // Carry out of the subtract path is the ARM not-borrow
  assign w_sum   = {1'b0, w_rd1} + {1'b0, w_src_b};
  assign w_diff  = {1'b0, w_rd1} + {1'b0, ~w_src_b} + 33'd1;
  assign w_v_add = (w_rd1[31] == w_src_b[31]) && (w_sum[31]  != w_rd1[31]);
  assign w_v_sub = (w_rd1[31] != w_src_b[31]) && (w_diff[31] != w_rd1[31]);

  assign w_br_off    = {{6{instr[23]}}, instr[23:0], 2'b00};
  assign w_br_target = w_pc_plus8 + w_br_off;

  // ALU operation select; memory accesses add or subtract the offset per U
  always_comb begin
    w_alu   = 32'd0;
    w_alu_c = 1'b0;
    w_alu_v = 1'b0;
    w_arith = 1'b0;
    if (w_is_dp) begin
      case (w_cmd)
        c_CMD_AND: w_alu = w_rd1 & w_src_b;
        c_CMD_ORR: w_alu = w_rd1 | w_src_b;
        c_CMD_ADD: begin
          w_alu   = w_sum[31:0];
          w_alu_c = w_sum[32];
          w_alu_v = w_v_add;
          w_arith = 1'b1;
        end
        c_CMD_SUB, c_CMD_CMP: begin
          w_alu   = w_diff[31:0];
          w_alu_c = w_diff[32];
          w_alu_v = w_v_sub;
          w_arith = 1'b1;
        end
        default: w_alu = 32'd0;
      endcase
    end else if (w_is_mem) begin
      w_alu = w_up ? w_sum[31:0] : w_diff[31:0];
    end else if (w_is_br) begin
      w_alu = w_br_target;
    end
  end

  assign alu_result = w_alu;
  assign w_result   = w_is_mem ? read_data : w_alu;
  assign pc         = r_pc;

  // PC and flag update; both clear asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= 32'd0;
      r_flags <= 4'b0000;
    end else begin
      if (w_reg_we && (w_rd == c_PC_IDX)) begin
        r_pc <= w_result;
      end else if (w_branch) begin
        r_pc <= w_br_target;
      end else begin
        r_pc <= w_pc_plus4;
      end
      if (w_flag_we) begin
        r_flags <= {w_alu[31], (w_alu == 32'd0),
                    w_arith & w_alu_c, w_arith & w_alu_v};
      end
    end
  end

  // Register file write port; contents are not reset
  always_ff @(posedge clk) begin
    if (w_reg_we && (w_rd != c_PC_IDX)) begin
      r_rf[w_rd] <= w_result;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arm_cpu.sv
// ============================================================================
// Module      : tb_arm_cpu
// Description : Directed self-checking bench for arm_cpu. Registers are
//               observed through STR write_data, flags through conditional
//               stores, and the ALU through alu_result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arm_cpu;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] read_data;
  logic        mem_write;
  logic [31:0] pc;
  logic [31:0] write_data;
  logic [31:0] alu_result;

  int checks;
  int errors;

  arm_cpu dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .read_data  (read_data),
    .mem_write  (mem_write),
    .pc         (pc),
    .write_data (write_data),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction on the falling edge; outputs settle 1 time unit later
  task automatic apply(input logic [31:0] i, input logic [31:0] d);
    @(negedge clk);
    instr     = i;
    read_data = d;
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    instr     = 32'h0;
    read_data = 32'h0;
    #1;
    chk("reset_pc", pc, 32'h0);
    @(posedge clk);
    #1;
    chk("reset_pc_hold", pc, 32'h0);

    // LDR R0,[R14] : Rn=14, Rd=0
    @(negedge clk);
    reset     = 1'b1;
    instr     = 32'hE41E0000;
    read_data = 32'hFFFFFFFF;
    #1;
    chk("first_pc", pc, 32'h0);
    chk("ldr_no_memwrite", {31'd0, mem_write}, 32'd0);
    // LDR R1,[R14]
    apply(32'hE41E1000, 32'h000000FF);
    chk("pc_after_ldr0", pc, 32'd4);
    // STR R0,[R1]
    apply(32'hE4010000, 32'h0);
    chk("pc_after_ldr1", pc, 32'd8);
    chk("str_addr", alu_result, 32'hFF);
    chk("str_data", write_data, 32'hFFFFFFFF);
    chk("str_memwrite", {31'd0, mem_write}, 32'd1);
    // ADD R2,R1,R1 / SUB R3,R2,R1 / AND R4,R3,R2 / ORR R5,R3,R2
    apply(32'hE0812001, 32'h0);
    chk("pc_after_str", pc, 32'd12);
    chk("add_result", alu_result, 32'h1FE);
    chk("add_no_memwrite", {31'd0, mem_write}, 32'd0);
    apply(32'hE0423001, 32'h0);
    chk("sub_result", alu_result, 32'hFF);
    apply(32'hE0034002, 32'h0);
    chk("and_result", alu_result, 32'hFE);
    apply(32'hE1835002, 32'h0);
    chk("orr_result", alu_result, 32'h1FF);
    // CMP R1,R3
    apply(32'hE1510003, 32'h0);
    chk("pc_after_dp4", pc, 32'd28);
    chk("cmp_result", alu_result, 32'h0);
    // B imm24=FFFFFE at pc=32 branches to itself
    apply(32'hEAFFFFFE, 32'h0);
    chk("pc_at_b_self", pc, 32'd32);
    // ADDNE R5,R1,R1 must not execute (Z=1)
    apply(32'h10815001, 32'h0);
    chk("b_self_target", pc, 32'd32);
    // STREQ R5,[R1] : executes, R5 still 1FF
    apply(32'h04015000, 32'h0);
    chk("pc_after_addne", pc, 32'd36);
    chk("streq_memwrite", {31'd0, mem_write}, 32'd1);
    chk("addne_suppressed", write_data, 32'h1FF);
    // STRNE suppressed
    apply(32'h14015000, 32'h0);
    chk("strne_memwrite", {31'd0, mem_write}, 32'd0);
    // STRCS executes (C=1 from CMP)
    apply(32'h24015000, 32'h0);
    chk("strcs_memwrite", {31'd0, mem_write}, 32'd1);
    // B imm24=1 at pc=48 -> 60
    apply(32'hEA000001, 32'h0);
    chk("pc_at_b_fwd", pc, 32'd48);
    // STR R2 / R3 / R4 to read the registers back
    apply(32'hE4012000, 32'h0);
    chk("b_fwd_target", pc, 32'd60);
    chk("r2_value", write_data, 32'h1FE);
    apply(32'hE4013000, 32'h0);
    chk("r3_value", write_data, 32'hFF);
    apply(32'hE4014000, 32'h0);
    chk("r4_value", write_data, 32'hFE);
    // ORR R8,R1,#0xFF ror 8
    apply(32'hE38184FF, 32'h0);
    chk("orr_imm_rot", alu_result, 32'hFF0000FF);
    // SUBS R9,R1,R0 : FF - FFFFFFFF = 100 with borrow (C=0)
    apply(32'hE0519000, 32'h0);
    chk("subs_result", alu_result, 32'h100);
    // STRCC R9 executes
    apply(32'h34019000, 32'h0);
    chk("strcc_memwrite", {31'd0, mem_write}, 32'd1);
    chk("r9_value", write_data, 32'h100);
    // STRHI suppressed (C=0)
    apply(32'h84019000, 32'h0);
    chk("strhi_memwrite", {31'd0, mem_write}, 32'd0);
    // LDR R10,[R1,#4] and LDR R10,[R1,#-4]
    apply(32'hE591A004, 32'h0);
    chk("ldr_up_addr", alu_result, 32'h103);
    apply(32'hE411A004, 32'h0);
    chk("ldr_down_addr", alu_result, 32'hFB);
    // EOR R2,R1,R1 is unsupported: no writes
    apply(32'hE0212001, 32'h0);
    chk("eor_no_memwrite", {31'd0, mem_write}, 32'd0);
    apply(32'hE4012000, 32'h0);
    chk("pc_after_eor", pc, 32'd100);
    chk("eor_no_regwrite", write_data, 32'h1FE);
    // ADD R11,R15,R1 : R15 reads as pc+8
    apply(32'hE08FB001, 32'h0);
    chk("r15_read", alu_result, 32'd104 + 32'd8 + 32'hFF);
    // LDR R15,[R14] loads the pc
    apply(32'hE41EF000, 32'h00000200);
    // ADDS R7,R0,R1 : FFFFFFFF + FF = FE, C=1, V=0
    apply(32'hE0907001, 32'h0);
    chk("ldr_pc_target", pc, 32'h200);
    chk("adds_result", alu_result, 32'hFE);
    // STRCS R7 executes, STRVS suppressed
    apply(32'h24017000, 32'h0);
    chk("adds_carry", {31'd0, mem_write}, 32'd1);
    chk("r7_value", write_data, 32'hFE);
    apply(32'h64017000, 32'h0);
    chk("adds_no_overflow", {31'd0, mem_write}, 32'd0);
    chk("pc_before_reset", pc, 32'h208);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_pc", pc, 32'h0);
    @(negedge clk);
    reset     = 1'b1;
    instr     = 32'hE41E0000;
    read_data = 32'h12345678;
    #1;
    chk("restart_pc", pc, 32'h0);
    // STRCS R0 suppressed: flags were cleared by reset
    apply(32'h24010000, 32'h0);
    chk("restart_pc_next", pc, 32'd4);
    chk("flags_cleared", {31'd0, mem_write}, 32'd0);
    apply(32'hE4010000, 32'h0);
    chk("restart_r0", write_data, 32'h12345678);
    chk("restart_pc_8", pc, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends on its own
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
